// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer: FSM states and
// boundary register indices for the default 5-stage depth.
package pipe_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_IMISS = 2'd1,
        ST_DMISS = 2'd2,
        ST_REDIR = 2'd3
    } state_e;

    localparam int B_IFID = 0;
    localparam int B_IDEX = 1;
    localparam int B_EXMA = 2;
    localparam int B_MAWB = 3;

endpackage

// File: rtl/pipe_stall_ctrl_miss_timer.sv
// Saturating cycle counter with clear/enable and an optional sticky flag that
// latches when the count reaches MISS_TIMEOUT-1 while enabled.
module miss_timer #(
    parameter int CNT_W        = 16,
    parameter int MISS_TIMEOUT = 64,
    parameter bit CMP_EN       = 1'b1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             flag
);

    localparam logic [CNT_W-1:0] CMP_VAL = CNT_W'(MISS_TIMEOUT - 1);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt  <= '0;
            flag <= 1'b0;
        end else begin
            if (clr)
                cnt <= '0;
            else if (en && cnt != {CNT_W{1'b1}})
                cnt <= cnt + 1'b1;
            if (CMP_EN && en && cnt == CMP_VAL)
                flag <= 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for an N-stage in-order pipeline.
// Define STALL_PERF_EN to add saturating miss/load-use performance counters.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int NUM_STAGES   = 5,
    parameter int MISS_TIMEOUT = 64,
    parameter int CNT_W        = 16
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  i_ICache_Miss,
    input  logic                  i_DCache_Miss,
    input  logic                  i_LoadUse,
    input  logic                  i_BranchFlush,
    output logic                  o_PC_Stall,
    output logic [NUM_STAGES-2:0] o_Stall,
    output logic [NUM_STAGES-2:0] o_Flush,
    output logic [1:0]            o_State,
    output logic                  o_Timeout
`ifdef STALL_PERF_EN
    ,
    output logic [CNT_W-1:0]      o_IMissCycles,
    output logic [CNT_W-1:0]      o_DMissCycles,
    output logic [CNT_W-1:0]      o_LoadUseCount
`endif
);

    localparam int NB = NUM_STAGES - 1;

    state_e          state, state_nxt;
    logic            redirect_pend, pend_set;
    logic            pc_stall_d;
    logic [NB-1:0]   stall_d, flush_d;
    logic            loaduse_hit;
    logic            in_miss;
    logic [CNT_W-1:0] tmo_cnt_unused;

    always_comb begin
        state_nxt   = state;
        pend_set    = 1'b0;
        pc_stall_d  = 1'b0;
        stall_d     = '0;
        flush_d     = '0;
        loaduse_hit = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (i_DCache_Miss) begin
                    pc_stall_d = 1'b1;
                    for (int k = 0; k < NUM_STAGES - 2; k++) stall_d[k] = 1'b1;
                    flush_d[NB-1] = 1'b1;
                    state_nxt = ST_DMISS;
                end else if (i_BranchFlush && i_ICache_Miss) begin
                    // Redirect arriving with the miss: remember it for REDIR.
                    pc_stall_d       = 1'b1;
                    flush_d[B_IFID]  = 1'b1;
                    flush_d[B_IDEX]  = 1'b1;
                    pend_set         = 1'b1;
                    state_nxt        = ST_IMISS;
                end else if (i_BranchFlush) begin
                    flush_d[B_IFID] = 1'b1;
                    flush_d[B_IDEX] = 1'b1;
                end else if (i_LoadUse) begin
                    pc_stall_d      = 1'b1;
                    stall_d[B_IFID] = 1'b1;
                    flush_d[B_IDEX] = 1'b1;
                    loaduse_hit     = 1'b1;
                end else if (i_ICache_Miss) begin
                    pc_stall_d      = 1'b1;
                    flush_d[B_IFID] = 1'b1;
                    state_nxt       = ST_IMISS;
                end
            end
            ST_IMISS: begin
                pc_stall_d      = 1'b1;
                flush_d[B_IFID] = 1'b1;
                if (i_BranchFlush) begin
                    flush_d[B_IDEX] = 1'b1;
                    pend_set        = 1'b1;
                end
                if (i_DCache_Miss)
                    state_nxt = ST_DMISS;
                else if (!i_ICache_Miss)
                    state_nxt = (redirect_pend || i_BranchFlush) ? ST_REDIR : ST_RUN;
            end
            ST_DMISS: begin
                // EX is frozen, so branch/load-use events are not acted on here.
                pc_stall_d = 1'b1;
                for (int k = 0; k < NUM_STAGES - 2; k++) stall_d[k] = 1'b1;
                flush_d[NB-1] = 1'b1;
                if (!i_DCache_Miss)
                    state_nxt = i_ICache_Miss ? ST_IMISS :
                                redirect_pend ? ST_REDIR : ST_RUN;
            end
            ST_REDIR: begin
                flush_d[B_IFID] = 1'b1;
                state_nxt = i_DCache_Miss ? ST_DMISS : ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state         <= ST_RUN;
            redirect_pend <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_REDIR)
                redirect_pend <= 1'b0;
            else if (pend_set)
                redirect_pend <= 1'b1;
        end
    end

    assign o_PC_Stall = pc_stall_d;
    assign o_Stall    = stall_d & ~flush_d;
    assign o_Flush    = flush_d;
    assign o_State    = state;
    assign in_miss    = (state == ST_IMISS) || (state == ST_DMISS);

    miss_timer #(.CNT_W(CNT_W), .MISS_TIMEOUT(MISS_TIMEOUT), .CMP_EN(1'b1)) u_tmo (
        .Clk  (Clk),
        .Rst  (Rst),
        .clr  (!in_miss),
        .en   (in_miss),
        .cnt  (tmo_cnt_unused),
        .flag (o_Timeout)
    );

`ifdef STALL_PERF_EN
    logic [2:0] perf_flag_unused;

    miss_timer #(.CNT_W(CNT_W), .MISS_TIMEOUT(MISS_TIMEOUT), .CMP_EN(1'b0)) u_perf_imiss (
        .Clk(Clk), .Rst(Rst), .clr(1'b0), .en(state == ST_IMISS),
        .cnt(o_IMissCycles), .flag(perf_flag_unused[0])
    );
    miss_timer #(.CNT_W(CNT_W), .MISS_TIMEOUT(MISS_TIMEOUT), .CMP_EN(1'b0)) u_perf_dmiss (
        .Clk(Clk), .Rst(Rst), .clr(1'b0), .en(state == ST_DMISS),
        .cnt(o_DMissCycles), .flag(perf_flag_unused[1])
    );
    miss_timer #(.CNT_W(CNT_W), .MISS_TIMEOUT(MISS_TIMEOUT), .CMP_EN(1'b0)) u_perf_lu (
        .Clk(Clk), .Rst(Rst), .clr(1'b0), .en(loaduse_hit),
        .cnt(o_LoadUseCount), .flag(perf_flag_unused[2])
    );
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl at default parameters.
module tb_pipe_stall_ctrl;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       ic, dc, lu, bf;
    logic       o_PC_Stall, o_Timeout;
    logic [3:0] o_Stall, o_Flush;
    logic [1:0] o_State;
`ifdef STALL_PERF_EN
    logic [15:0] o_IMissCycles, o_DMissCycles, o_LoadUseCount;
`endif

    int n_cmp = 0;
    int n_err = 0;

    pipe_stall_ctrl dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .i_ICache_Miss (ic),
        .i_DCache_Miss (dc),
        .i_LoadUse     (lu),
        .i_BranchFlush (bf),
        .o_PC_Stall    (o_PC_Stall),
        .o_Stall       (o_Stall),
        .o_Flush       (o_Flush),
        .o_State       (o_State),
        .o_Timeout     (o_Timeout)
`ifdef STALL_PERF_EN
        ,
        .o_IMissCycles (o_IMissCycles),
        .o_DMissCycles (o_DMissCycles),
        .o_LoadUseCount(o_LoadUseCount)
`endif
    );

    always #5 Clk = ~Clk;

    // {state, pc_stall, stall, flush}
    function automatic logic [10:0] obs();
        return {o_State, o_PC_Stall, o_Stall, o_Flush};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        logic [10:0] o;
        Rst = 1'b0; ic = 0; dc = 0; lu = 0; bf = 0;
        #3;
        o = obs();
        n_cmp++;
        if (o !== 11'd0) begin n_err++; $display("FAIL reset_outputs: got %h want %h", o, 11'd0); end
        n_cmp++;
        if (o_Timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", o_Timeout); end
`ifdef STALL_PERF_EN
        n_cmp++;
        if ({o_IMissCycles, o_DMissCycles, o_LoadUseCount} !== 48'd0) begin
            n_err++; $display("FAIL reset_perf: got %h want 0", {o_IMissCycles, o_DMissCycles, o_LoadUseCount});
        end
`endif
        #1 Rst = 1'b1;
        tick();
    endtask

    task automatic test_loaduse();
        logic [10:0] o;
        lu = 1; #1;
        o = obs();
        n_cmp++;
        if (o !== {2'd0, 1'b1, 4'b0001, 4'b0010}) begin n_err++; $display("FAIL loaduse_cycle: got %h want %h", o, {2'd0, 1'b1, 4'b0001, 4'b0010}); end
        tick(); lu = 0; #1;
        o = obs();
        n_cmp++;
        if (o !== 11'd0) begin n_err++; $display("FAIL loaduse_after: got %h want %h", o, 11'd0); end
        tick();
    endtask

    task automatic test_branchflush();
        logic [10:0] o;
        bf = 1; #1;
        o = obs();
        n_cmp++;
        if (o !== {2'd0, 1'b0, 4'b0000, 4'b0011}) begin n_err++; $display("FAIL bflush_run: got %h want %h", o, {2'd0, 1'b0, 4'b0000, 4'b0011}); end
        tick(); bf = 0; #1;
        o = obs();
        n_cmp++;
        if (o !== 11'd0) begin n_err++; $display("FAIL bflush_after: got %h want %h", o, 11'd0); end
        tick();
    endtask

    task automatic test_imiss_redirect();
        logic [10:0] o;
        logic [10:0] exp [0:5];
        exp[0] = {2'd0, 1'b1, 4'b0000, 4'b0001};
        exp[1] = {2'd1, 1'b1, 4'b0000, 4'b0011};
        exp[2] = {2'd1, 1'b1, 4'b0000, 4'b0001};
        exp[3] = {2'd1, 1'b1, 4'b0000, 4'b0001};
        exp[4] = {2'd3, 1'b0, 4'b0000, 4'b0001};
        exp[5] = 11'd0;
        for (int c = 0; c < 6; c++) begin
            ic = (c < 3);
            bf = (c == 1);
            #1;
            o = obs();
            n_cmp++;
            if (o !== exp[c]) begin n_err++; $display("FAIL imiss_redir_c%0d: got %h want %h", c, o, exp[c]); end
            tick();
        end
    endtask

    task automatic test_dmiss();
        logic [10:0] o;
        logic [10:0] exp [0:6];
        for (int c = 0; c < 6; c++) exp[c] = {2'd2, 1'b1, 4'b0111, 4'b1000};
        exp[0] = {2'd0, 1'b1, 4'b0111, 4'b1000};
        exp[6] = 11'd0;
        for (int c = 0; c < 7; c++) begin
            dc = (c < 5);
            bf = (c == 2);
            lu = (c == 3);
            #1;
            o = obs();
            n_cmp++;
            if (o !== exp[c]) begin n_err++; $display("FAIL dmiss_c%0d: got %h want %h", c, o, exp[c]); end
            tick();
        end
    endtask

    task automatic test_dmiss_to_imiss();
        logic [10:0] o;
        logic [10:0] exp [0:5];
        exp[0] = {2'd0, 1'b1, 4'b0111, 4'b1000};
        exp[1] = {2'd2, 1'b1, 4'b0111, 4'b1000};
        exp[2] = {2'd2, 1'b1, 4'b0111, 4'b1000};
        exp[3] = {2'd1, 1'b1, 4'b0000, 4'b0001};
        exp[4] = {2'd1, 1'b1, 4'b0000, 4'b0001};
        exp[5] = 11'd0;
        for (int c = 0; c < 6; c++) begin
            dc = (c < 2);
            ic = (c < 4);
            #1;
            o = obs();
            n_cmp++;
            if (o !== exp[c]) begin n_err++; $display("FAIL dmiss_imiss_c%0d: got %h want %h", c, o, exp[c]); end
            tick();
        end
    endtask

    task automatic test_timeout();
        ic = 1;
        repeat (64) tick();
        n_cmp++;
        if (o_Timeout !== 1'b0) begin n_err++; $display("FAIL timeout_early: got %b want 0", o_Timeout); end
        tick();
        n_cmp++;
        if (o_Timeout !== 1'b1) begin n_err++; $display("FAIL timeout_rise: got %b want 1", o_Timeout); end
        repeat (4) tick();
        ic = 0;
        tick();
        n_cmp++;
        if ({o_State, o_Timeout} !== {2'd0, 1'b1}) begin n_err++; $display("FAIL timeout_sticky: got %h want %h", {o_State, o_Timeout}, {2'd0, 1'b1}); end
        #2 Rst = 1'b0;
        #1;
        n_cmp++;
        if (o_Timeout !== 1'b0) begin n_err++; $display("FAIL timeout_reset: got %b want 0", o_Timeout); end
        #1 Rst = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_dmiss();
        logic [10:0] o;
        ic = 1; bf = 1;      // RUN -> IMISS with redirect pending
        tick();
        bf = 0; dc = 1;      // IMISS -> DMISS, pending redirect kept
        tick();
        tick();
        #2 Rst = 1'b0;
        ic = 0; dc = 0;
        #1;
        o = obs();
        n_cmp++;
        if (o !== 11'd0) begin n_err++; $display("FAIL rst_mid_dmiss: got %h want %h", o, 11'd0); end
`ifdef STALL_PERF_EN
        n_cmp++;
        if ({o_IMissCycles, o_DMissCycles, o_LoadUseCount} !== 48'd0) begin
            n_err++; $display("FAIL rst_mid_perf: got %h want 0", {o_IMissCycles, o_DMissCycles, o_LoadUseCount});
        end
`endif
        #1 Rst = 1'b1;
        tick();
        // Pending redirect must be gone: a plain I-miss returns straight to RUN.
        ic = 1;
        tick();
        ic = 0; #1;
        n_cmp++;
        if (o_State !== 2'd1) begin n_err++; $display("FAIL rst_pend_imiss: got %0d want 1", o_State); end
        tick();
        n_cmp++;
        if (o_State !== 2'd0) begin n_err++; $display("FAIL rst_pend_lost: got %0d want 0", o_State); end
        tick();
    endtask

    initial begin
        test_reset();
        test_loaduse();
        test_branchflush();
        test_imiss_redirect();
        test_dmiss();
        test_dmiss_to_imiss();
        test_timeout();
        test_reset_mid_dmiss();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
